tmss_bios_loader: RTL and testbench
===================================

Name: tmss_bios_loader

Overview:
Upstream feeder for the TMSS block. It receives the TMSS boot ROM image as a byte stream from the host/loader side and stores it in an internal 1K x 16 RAM. It serves tmss_data for the TMSS block's tmss_address. It drives tmss_enable only once a complete image is loaded and the user option is on.

Parameters:
ADDR_W, 10, word-address width; image size is 2^ADDR_W words (2048 bytes at default).
INIT_ENABLE, 0, reset value of the internal enable latch (0 = TMSS off until configured).

Ports:
MCLK  in  1  system clock; everything is synchronous to its rising edge.
reset  in  1  synchronous, active-high reset.
cfg_tmss_on  in  1  user option: TMSS present; sampled every cycle.
ld_start  in  1  one-cycle pulse that begins a new image load.
ld_valid  in  1  byte-stream valid.
ld_data  in  8  byte-stream data; big-endian, so the even byte is the high half of the word.
ld_ready  out  1  loader can accept a byte this cycle.
tmss_address  in  ADDR_W  word address from the TMSS block.
tmss_data  out  16  ROM word for tmss_address.
tmss_enable  out  1  enables the TMSS block.
loaded  out  1  a complete image is resident.
checksum  out  16  running mod-2^16 sum of the words written.
ld_overrun  out  1  sticky flag: a byte was offered after the image was complete.

Behaviour:
- Reset values:
  - state IDLE, ld_ready=0, loaded=0, tmss_enable=0, tmss_data=0, checksum=0, ld_overrun=0.
  - Word counter = 0, high-byte register = 0.
  - RAM contents are not reset.
- Transfer rule: a byte moves only when ld_valid & ld_ready in the same cycle. ld_valid may stay high across cycles.
- States:
  - IDLE: ld_ready=0. On ld_start go to LOAD_HI.
  - LOAD_HI: ld_ready=1. On transfer, latch ld_data into hi_reg and go to LOAD_LO.
  - LOAD_LO: ld_ready=1. On transfer, form word {hi_reg, ld_data} and go to WRITE.
  - WRITE (1 cycle): ld_ready=0. Write the word to RAM[counter] and add it to checksum (16-bit wrap). If counter == 2^ADDR_W-1, go to DONE; otherwise increment counter and go to LOAD_HI.
  - DONE: ld_ready=0 and loaded=1. ld_valid=1 here sets ld_overrun.
- Load throughput: at most one word every 3 cycles.
- ld_start handling:
  - ld_start has priority over every other event in every state, including mid-load and DONE.
  - Next cycle: counter=0, checksum=0, loaded=0, ld_overrun=0, state LOAD_HI.
  - A byte transferred in the same cycle as ld_start is discarded.
- reset mid-load: returns to the reset values. A partial image stays in RAM but loaded=0.
- Read path:
  - tmss_data is registered with 1-cycle latency: tmss_data(t+1) = RAM[tmss_address(t)] when loaded=1, else 0.
  - Read and write are independent ports. A read of the address being written in the same cycle returns the old contents.
- tmss_enable is registered: tmss_enable(t+1) = loaded(t) & cfg_tmss_on(t) & ~reset(t).
  - It is therefore 0 throughout any load.
  - It follows cfg_tmss_on with 1-cycle latency when loaded=1.
- checksum holds its final value in DONE until the next ld_start or reset.

Decomposition:
- Shared package tmss_pkg holds:
  - loader state encoding (IDLE, LOAD_HI, LOAD_LO, WRITE, DONE);
  - TMSS_ADDR_W = 10;
  - TMSS_IMAGE_BYTES = 2048.
- One sub-module: tmss_bios_ram, a simple dual-port 2^ADDR_W x 16 RAM.
  - One write port and one registered read port.
  - Read-before-write; no reset.
- The FSM, counter, checksum and output gating live in the top module.

Test Plan:
- After reset with no load, sweep tmss_address 0..3 -> tmss_data=0, loaded=0, tmss_enable=0, ld_ready=0 throughout.
- Pulse ld_start, stream 2048 bytes with ld_valid held high, byte i = i[7:0] -> word 0 = 0x0001, word 1 = 0x0203, word 1023 = 0xFEFF.
  - Expect loaded=1 and ld_ready=0 after the final WRITE.
  - With cfg_tmss_on=1, expect tmss_enable=1 one cycle later.
  - checksum equals the mod-2^16 sum of the words (the bench computes and compares).
- Pulse ld_start after 100 bytes, then load a full image of byte 0xA5 -> every word reads 0xA5A5, checksum=0x9400, and no trace of the first load remains.
- Toggle ld_valid randomly (about 50%) during a full load -> RAM contents and checksum are identical to the back-to-back run; no byte is lost or duplicated.
- In DONE, drive ld_valid=1 for one cycle -> ld_overrun=1 and stays set; RAM is unchanged. A following ld_start clears it.
- Assert reset at byte 1000 of a load -> loaded=0, tmss_enable=0 and tmss_data=0 next cycle. The next ld_start plus a full load completes normally.

Source files
------------

// File: rtl/tmss_pkg.sv
// Shared definitions for the TMSS boot-ROM loader: loader states and image geometry.
package tmss_pkg;

   localparam int unsigned TMSS_ADDR_W      = 10;
   localparam int unsigned TMSS_IMAGE_BYTES = 2048;

   typedef enum logic [2:0] {
      StIdle,
      StLoadHi,
      StLoadLo,
      StWrite,
      StDone
   } ld_state_e;

endpackage

// File: rtl/tmss_bios_ram.sv
// Simple dual-port 2^AddrW x 16 RAM: one write port, one registered read port,
// read-before-write on an address collision, no reset.
module tmss_bios_ram #(
   parameter int unsigned AddrW = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AddrW-1:0]  waddr_i,
   input  logic [15:0]       wdata_i,
   input  logic [AddrW-1:0]  raddr_i,
   output logic [15:0]       rdata_o
);

   logic [15:0] mem_q [2**AddrW];
   logic [15:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tmss_bios_loader.sv
// Loads the TMSS boot ROM image from a big-endian byte stream into local RAM and serves it
// to the TMSS block; tmss_enable is only asserted once a full image is resident.
module tmss_bios_loader
   import tmss_pkg::*;
#(
   parameter int unsigned ADDR_W      = TMSS_ADDR_W,
   parameter bit          INIT_ENABLE = 1'b0
) (
   input  logic              MCLK,
   input  logic              reset,
   input  logic              cfg_tmss_on,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] tmss_address,
   output logic [15:0]       tmss_data,
   output logic              tmss_enable,
   output logic              loaded,
   output logic [15:0]       checksum,
   output logic              ld_overrun
);

   ld_state_e         state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [7:0]        hi_q;
   logic [15:0]       word_q;
   logic [15:0]       checksum_q;
   logic              ld_ready_q;
   logic              loaded_q;
   logic              overrun_q;
   logic              enable_q;
   logic              rd_gate_q;
   logic              xfer;
   logic              ram_we;
   logic [15:0]       ram_rdata;

   assign xfer   = ld_valid & ld_ready_q;
   // ld_start and reset both pre-empt the pending write of a half-finished cycle.
   assign ram_we = (state_q == StWrite) & ~reset & ~ld_start;

   always_ff @(posedge MCLK) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         hi_q       <= '0;
         word_q     <= '0;
         checksum_q <= '0;
         ld_ready_q <= 1'b0;
         loaded_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (ld_start) begin
         state_q    <= StLoadHi;
         cnt_q      <= '0;
         checksum_q <= '0;
         ld_ready_q <= 1'b1;
         loaded_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StLoadHi: begin
               if (xfer) begin
                  hi_q    <= ld_data;
                  state_q <= StLoadLo;
               end
            end
            StLoadLo: begin
               if (xfer) begin
                  word_q     <= {hi_q, ld_data};
                  ld_ready_q <= 1'b0;
                  state_q    <= StWrite;
               end
            end
            StWrite: begin
               checksum_q <= checksum_q + word_q;
               if (&cnt_q) begin
                  loaded_q <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  cnt_q      <= cnt_q + ADDR_W'(1);
                  ld_ready_q <= 1'b1;
                  state_q    <= StLoadHi;
               end
            end
            StDone: begin
               if (ld_valid) begin
                  overrun_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         enable_q  <= INIT_ENABLE;
         rd_gate_q <= 1'b0;
      end else begin
         enable_q  <= loaded_q & cfg_tmss_on;
         rd_gate_q <= loaded_q;
      end
   end

   tmss_bios_ram #(
      .AddrW (ADDR_W)
   ) u_ram (
      .clk_i   (MCLK),
      .we_i    (ram_we),
      .waddr_i (cnt_q),
      .wdata_i (word_q),
      .raddr_i (tmss_address),
      .rdata_o (ram_rdata)
   );

   assign ld_ready    = ld_ready_q;
   assign loaded      = loaded_q;
   assign checksum    = checksum_q;
   assign ld_overrun  = overrun_q;
   assign tmss_enable = enable_q;
   assign tmss_data   = rd_gate_q ? ram_rdata : 16'h0000;

endmodule

// File: tb/tb_tmss_bios_loader.sv
// Bench for tmss_bios_loader: a byte-count level model of the loader checked every cycle,
// plus literal expectations for known images.
module tb_tmss_bios_loader;

   localparam int unsigned AW    = 10;
   localparam int unsigned WORDS = 1 << AW;
   localparam int unsigned BYTES = 2 * WORDS;

   logic          MCLK = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_tmss_on = 1'b0;
   logic          ld_start = 1'b0;
   logic          ld_valid = 1'b0;
   logic [7:0]    ld_data = 8'h00;
   logic          ld_ready;
   logic [AW-1:0] tmss_address = '0;
   logic [15:0]   tmss_data;
   logic          tmss_enable;
   logic          loaded;
   logic [15:0]   checksum;
   logic          ld_overrun;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   tmss_bios_loader #(
      .ADDR_W      (AW),
      .INIT_ENABLE (1'b0)
   ) dut (
      .MCLK         (MCLK),
      .reset        (reset),
      .cfg_tmss_on  (cfg_tmss_on),
      .ld_start     (ld_start),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .tmss_address (tmss_address),
      .tmss_data    (tmss_data),
      .tmss_enable  (tmss_enable),
      .loaded       (loaded),
      .checksum     (checksum),
      .ld_overrun   (ld_overrun)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: tracks bytes accepted since ld_start; every second byte is followed by one
   // cycle in which the word lands in memory and the sum.
   logic [15:0] m_mem [WORDS];
   bit          m_loading = 0, m_bubble = 0, m_loaded = 0, m_ovr = 0, m_en = 0, m_ready = 0;
   int          m_nbytes = 0;
   logic [7:0]  m_hi = '0;
   logic [15:0] m_word = '0, m_cks = '0, m_data = '0;
   logic [15:0] nx_data;
   bit          nx_en;

   initial for (int k = 0; k < WORDS; k++) m_mem[k] = '0;

   always @(posedge MCLK) begin
      nx_data = m_loaded ? m_mem[tmss_address] : 16'h0000;
      nx_en   = m_loaded & cfg_tmss_on & ~reset;
      if (reset) begin
         m_loading = 0; m_bubble = 0; m_loaded = 0; m_ovr = 0; m_nbytes = 0;
         m_cks = '0; nx_data = '0;
      end else if (ld_start) begin
         m_loading = 1; m_bubble = 0; m_loaded = 0; m_ovr = 0; m_nbytes = 0; m_cks = '0;
      end else if (m_bubble) begin
         m_mem[m_nbytes/2 - 1] = m_word;
         m_cks    = m_cks + m_word;
         m_bubble = 0;
         if (m_nbytes == BYTES) begin
            m_loading = 0;
            m_loaded  = 1;
         end
      end else if (m_loading && ld_valid) begin
         if (m_nbytes % 2 == 0) m_hi = ld_data;
         else begin
            m_word   = {m_hi, ld_data};
            m_bubble = 1;
         end
         m_nbytes++;
      end else if (m_loaded && ld_valid) begin
         m_ovr = 1;
      end
      m_data  = nx_data;
      m_en    = nx_en;
      m_ready = m_loading & ~m_bubble;
   end

   always @(negedge MCLK) begin
      if (cmp_en) begin
         check("ld_ready", ld_ready, m_ready);
         check("loaded", loaded, m_loaded);
         check("tmss_enable", tmss_enable, m_en);
         check("tmss_data", tmss_data, m_data);
         check("checksum", checksum, m_cks);
         check("ld_overrun", ld_overrun, m_ovr);
      end
   end

   task automatic tick;
      @(posedge MCLK);
      #1;
   endtask

   task automatic pulse_start(input bit with_byte);
      ld_start = 1'b1;
      ld_valid = with_byte;
      ld_data  = 8'h77;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
   endtask

   // mode 0: byte i = i[7:0]; mode 1: constant 0xA5
   task automatic send_bytes(input int n, input int mode, input bit rnd);
      int i = 0;
      int guard = 0;
      bit v;
      while (i < n && guard < 4 * BYTES) begin
         v        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_valid = v;
         ld_data  = (mode == 1) ? 8'hA5 : i[7:0];
         if (v && m_ready) i++;
         tick();
         guard++;
      end
      ld_valid = 1'b0;
      check("send_budget", i, n);
   endtask

   task automatic wait_loaded;
      int guard = 0;
      while (!m_loaded && guard < 8) begin
         tick();
         guard++;
      end
      check("loaded_lit", loaded, 1'b1);
   endtask

   task automatic read_word(input int addr, output logic [15:0] data);
      tmss_address = AW'(addr);
      tick();
      data = tmss_data;
   endtask

   function automatic logic [15:0] ramp_word(input int k);
      logic [7:0] hi, lo;
      hi = 8'((2 * k) % 256);
      lo = 8'((2 * k + 1) % 256);
      return {hi, lo};
   endfunction

   logic [15:0] rd;

   initial begin
      tick();
      tick();
      reset = 1'b0;
      cmp_en = 1'b1;

      // Idle after reset
      for (int a = 0; a < 4; a++) begin
         read_word(a, rd);
         check("idle_data", rd, 16'h0000);
         check("idle_loaded", loaded, 1'b0);
         check("idle_enable", tmss_enable, 1'b0);
         check("idle_ready", ld_ready, 1'b0);
      end

      // Back-to-back ramp image
      cfg_tmss_on = 1'b1;
      pulse_start(1'b0);
      send_bytes(BYTES, 0, 1'b0);
      wait_loaded();
      check("done_ready", ld_ready, 1'b0);
      check("enable_lag", tmss_enable, 1'b0);
      tick();
      check("enable_on", tmss_enable, 1'b1);
      check("ramp_cks", checksum, 16'h0000);
      read_word(0, rd);    check("ramp_w0", rd, 16'h0001);
      read_word(1, rd);    check("ramp_w1", rd, 16'h0203);
      read_word(1023, rd); check("ramp_w1023", rd, 16'hFEFF);

      // Restart mid-load (with a byte offered in the start cycle), then 0xA5 image
      pulse_start(1'b0);
      send_bytes(100, 0, 1'b0);
      pulse_start(1'b1);
      check("restart_enable", tmss_enable, 1'b0);
      send_bytes(BYTES, 1, 1'b0);
      wait_loaded();
      check("a5_cks", checksum, 16'h9400);
      for (int a = 0; a < WORDS; a++) begin
         read_word(a, rd);
         check("a5_word", rd, 16'hA5A5);
      end

      // Ramp image with ~50% valid duty
      pulse_start(1'b0);
      send_bytes(BYTES, 0, 1'b1);
      wait_loaded();
      check("rnd_cks", checksum, 16'h0000);
      for (int a = 0; a < WORDS; a++) begin
         read_word(a, rd);
         check("rnd_word", rd, ramp_word(a));
      end

      // Overrun in DONE
      ld_valid = 1'b1;
      ld_data  = 8'hEE;
      tick();
      ld_valid = 1'b0;
      check("ovr_set", ld_overrun, 1'b1);
      tick(); tick(); tick();
      check("ovr_sticky", ld_overrun, 1'b1);
      read_word(5, rd);
      check("ovr_ram", rd, 16'h0A0B);
      check("ovr_cks", checksum, 16'h0000);
      pulse_start(1'b0);
      check("ovr_clear", ld_overrun, 1'b0);

      // Reset at byte 1000, then a clean reload
      tmss_address = AW'(7);
      send_bytes(1000, 0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_loaded", loaded, 1'b0);
      check("rst_enable", tmss_enable, 1'b0);
      check("rst_data", tmss_data, 16'h0000);
      check("rst_ready", ld_ready, 1'b0);
      tick();
      pulse_start(1'b0);
      send_bytes(BYTES, 0, 1'b0);
      wait_loaded();
      check("reload_cks", checksum, 16'h0000);
      read_word(1023, rd);
      check("reload_w1023", rd, 16'hFEFF);
      tick();
      check("reload_enable", tmss_enable, 1'b1);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
